// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and burst memory.
// master: the arbiter's view; slave: the caches/memory environment.
interface cache_arbiter_if #(
  parameter int unsigned BEATS = 4
);
  localparam int unsigned LineW = 64 * BEATS;

  // Instruction cache
  logic              icache_read;
  logic [31:0]       icache_address;
  logic [LineW-1:0]  icache_rdata;
  logic              icache_resp;

  // Data cache
  logic              dcache_read;
  logic              dcache_write;
  logic [31:0]       dcache_address;
  logic [LineW-1:0]  dcache_wdata;
  logic [LineW-1:0]  dcache_rdata;
  logic              dcache_resp;

  // Burst memory
  logic [31:0]       bmem_address;
  logic              bmem_read;
  logic              bmem_write;
  logic [63:0]       bmem_wdata;
  logic              bmem_ready;
  logic [63:0]       bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output bmem_address, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid
  );

  modport slave (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  bmem_address, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester cache-line arbiter in front of a 64-bit burst memory.
// The dcache wins ties unless it won the previous grant, so neither side starves.
module cache_arbiter #(
  parameter int unsigned BEATS = 4
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.master bus
);
  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   last_d_q;   // previous grant went to the dcache
  logic                   sel_d_q;    // current transaction belongs to the dcache
  logic                   is_wr_q;
  logic                   cmd_ok_q;   // read command already accepted by memory
  logic [26:0]            addr_q;
  logic [BEATS-1:0][63:0] line_q;     // writeback source or fill destination
  logic [CntW-1:0]        cnt_q;

  logic i_req, d_req, grant_d, grant_i;
  logic in_rd, rd_cmd, beat_rd, beat_wr, last_beat, done;

  assign i_req     = bus.icache_read;
  assign d_req     = bus.dcache_read | bus.dcache_write;
  assign in_rd     = (state_q == StIRd) || (state_q == StDRd);
  assign rd_cmd    = in_rd && !cmd_ok_q;
  assign beat_rd   = in_rd && cmd_ok_q && bus.bmem_rvalid;
  assign beat_wr   = (state_q == StDWr) && bus.bmem_ready;
  assign last_beat = (cnt_q == LastBeat);
  assign done      = (state_q == StDone);

  // Next-state logic and grant decision
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_req && (!i_req || !last_d_q)) begin
          grant_d = 1'b1;
          // Simultaneous read+write is treated as a writeback
          state_d = bus.dcache_write ? StDWr : StDRd;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = StIRd;
        end
      end
      StIRd, StDRd: if (beat_rd && last_beat) state_d = StDone;
      StDWr:        if (beat_wr && last_beat) state_d = StDone;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Grant latching, beat counting and line buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d_q <= 1'b0;
      sel_d_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      cmd_ok_q <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
    end else if (grant_d) begin
      last_d_q <= 1'b1;
      sel_d_q  <= 1'b1;
      is_wr_q  <= bus.dcache_write;
      cmd_ok_q <= 1'b0;
      addr_q   <= bus.dcache_address[31:5];
      line_q   <= bus.dcache_wdata;
      cnt_q    <= '0;
    end else if (grant_i) begin
      last_d_q <= 1'b0;
      sel_d_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      cmd_ok_q <= 1'b0;
      addr_q   <= bus.icache_address[31:5];
      cnt_q    <= '0;
    end else begin
      if (rd_cmd && bus.bmem_ready) cmd_ok_q <= 1'b1;
      if (beat_rd) line_q[cnt_q] <= bus.bmem_rdata;
      if ((beat_rd || beat_wr) && !last_beat) cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Moore outputs; the idle cache always sees zero resp/rdata
  always_comb begin
    bus.bmem_address = {addr_q, 5'b0};
    bus.bmem_read    = rd_cmd;
    bus.bmem_write   = (state_q == StDWr);
    bus.bmem_wdata   = (state_q == StDWr) ? line_q[cnt_q] : 64'd0;
    bus.icache_resp  = done && !sel_d_q;
    bus.dcache_resp  = done && sel_d_q;
    bus.icache_rdata = (done && !sel_d_q) ? line_q : '0;
    bus.dcache_rdata = (done && sel_d_q && !is_wr_q) ? line_q : '0;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: BEATS, default 4, number of 64-bit memory beats per cache line; line width is 64*BEATS (256 at default).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-004 icache_read  in  1  instruction-cache line-fill request; held until icache_resp.
REQ-005 icache_address  in  32  instruction-cache line address; bits [4:0] ignored.
REQ-006 icache_rdata  out  256  filled line; valid while icache_resp=1.
REQ-007 icache_resp  out  1  one-cycle completion pulse.
REQ-008 dcache_read, dcache_write  in  1 each  data-cache fill and writeback requests; held until dcache_resp.
REQ-009 dcache_address  in  32  data-cache line address; bits [4:0] ignored.
REQ-010 dcache_wdata  in  256  writeback line.
REQ-011 dcache_rdata  out  256  filled line; valid while dcache_resp=1.
REQ-012 dcache_resp  out  1  one-cycle completion pulse.
REQ-013 bmem_address  out  32  burst address, always {addr[31:5],5'b0}.
REQ-014 bmem_read, bmem_write  out  1 each  burst command strobes.
REQ-015 bmem_wdata  out  64  current write beat.
REQ-016 bmem_ready  in  1  memory accepts the command or write beat this cycle.
REQ-017 bmem_rdata  in  64  read beat; bmem_rvalid  in  1  beat valid.

Function
REQ-018 FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
REQ-019 IDLE arbitration: with a single requester, grant it. With both caches requesting, grant the dcache unless the previous grant was dcache, in which case grant the icache (one-bit last-grant flag).
REQ-020 dcache_read and dcache_write both high: treat as a write, entering D_WR.
REQ-021 Grant latches the requester, address and wdata; later changes to the request inputs are ignored until DONE.
REQ-022 I_RD/D_RD: hold bmem_read=1 with the latched address until a cycle with bmem_ready=1; then deassert and wait for beats.
REQ-023 Read beats: the k-th bmem_rvalid beat (k=0..BEATS-1) is stored to line bits [64k+63:64k]. After the last beat, go to DONE. bmem_rvalid outside a read state is ignored.
REQ-024 D_WR: bmem_write=1 and bmem_wdata = beat k of the latched line. k advances only on bmem_ready=1. After beat BEATS-1 is accepted, go to DONE.
REQ-025 Beat counter: width clog2(BEATS); cleared on grant; no wrap beyond BEATS-1.
REQ-026 DONE: assert exactly one cycle of resp to the latched requester, with rdata valid for reads. Next state is IDLE.
REQ-027 resp and rdata for the non-granted cache are 0 at all times.
REQ-028 IDLE never asserts bmem_read or bmem_write.
REQ-029 Minimum read latency, request cycle to resp: 1 (grant) + 1 (command accepted) + BEATS (beats) + 1 (DONE) cycles.
REQ-030 A request withdrawn mid-transaction still completes on memory, and resp still pulses.

Reset
REQ-031 While rst=0 at posedge: state=IDLE, counter=0, last-grant=icache, and all outputs 0 (including line buffer contents seen on rdata).
REQ-032 Reset mid-burst aborts the transaction: no resp is issued, and straggling bmem_rvalid beats after reset are ignored.

Verification
REQ-033 icache_read, addr 0x4000_0024, ready=1, beats 0x11..,0x22..,0x33..,0x44.. -> bmem_address 0x4000_0020, one-cycle icache_resp, rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-034 Both caches request in the same cycle from reset -> dcache served first; icache served next, with no idle gap beyond one IDLE cycle.
REQ-035 dcache_write, wdata = four distinct words, bmem_ready toggling 1,0,1,0 -> each beat held while ready=0, exactly 4 beats accepted in order, then dcache_resp.
REQ-036 Back-to-back dcache requests with icache continuously requesting -> grants alternate D, I, D; the icache is never starved.
REQ-037 rst=0 after 2 read beats -> no resp, outputs 0 next cycle; later beats ignored; a fresh request completes correctly.
REQ-038 bmem_ready=0 for 5 cycles in D_RD -> bmem_read held high with a stable address for all 5 cycles.
